// File: rtl/sar_search_controller_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_search_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sar_state_e;

    // Probe counter must represent WIDTH+1, the worst-case number of samples.
    function automatic int unsigned sar_pcw(input int unsigned width);
        return $clog2(width + 2);
    endfunction

    // Upper middle of the inclusive range [lo, hi].
    function automatic int unsigned sar_mid(input int unsigned lo, input int unsigned hi);
        return (lo + hi + 1) >> 1;
    endfunction

endpackage

// File: rtl/sar_search_controller_if.sv
// Handshake and comparator-facing signals of the search controller.
interface sar_search_controller_if #(
    parameter int WIDTH = 4,
    parameter int PCW   = sar_search_controller_pkg::sar_pcw(WIDTH)
) ();

    logic             start;
    logic             cmp_g;
    logic             cmp_e;
    logic             cmp_l;
    logic [WIDTH-1:0] guess;
    logic             busy;
    logic             done;
    logic             found;
    logic             error;
    logic [WIDTH-1:0] result;
    logic [PCW-1:0]   probes;

    modport master (
        input  start, cmp_g, cmp_e, cmp_l,
        output guess, busy, done, found, error, result, probes
    );

    modport slave (
        output start, cmp_g, cmp_e, cmp_l,
        input  guess, busy, done, found, error, result, probes
    );

endinterface

// File: rtl/sar_settle_timer.sv
// Down-counter that holds off sampling for CYCLES cycles after each new guess.
module sar_settle_timer #(
    parameter int CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(CYCLES - 1);
        end else if (en && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    assign expire = (cnt_q == '0);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sar_search_controller.sv
// Binary-searches the comparator's hidden A operand by driving guesses on B.
module sar_search_controller
    import sar_search_controller_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 0,
    parameter int PCW    = sar_pcw(WIDTH)
) (
    input logic                  clk,
    input logic                  rst,
    sar_search_controller_if.master bus
);

    localparam logic [WIDTH:0]   HI_INIT     = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0]   ONE_EXT     = (WIDTH + 1)'(1);
    localparam logic [WIDTH-1:0] GUESS_INIT  = {1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [PCW-1:0]   PROBE_MAX   = PCW'(WIDTH + 1);
    localparam sar_state_e       PROBE_STATE = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;

    sar_state_e       state_q, state_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH:0]   lo_q, lo_d;
    logic [WIDTH:0]   hi_q, hi_d;
    logic [PCW-1:0]   probes_q, probes_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             found_q, found_d;
    logic             error_q, error_d;

    logic [WIDTH:0]   lo_n, hi_n;
    logic [2:0]       cmp_vec;
    logic             settle_expire;

    generate
        if (SETTLE > 0) begin : g_timer
            sar_settle_timer #(.CYCLES(SETTLE)) u_timer (
                .clk    (clk),
                .rst    (rst),
                .load   (state_d == ST_SETTLE && state_q != ST_SETTLE),
                .en     (state_q == ST_SETTLE),
                .expire (settle_expire)
            );
        end else begin : g_no_timer
            assign settle_expire = 1'b1;
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        guess_d  = guess_q;
        result_d = result_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        probes_d = probes_q;
        found_d  = found_q;
        error_d  = error_q;
        lo_n     = lo_q;
        hi_n     = hi_q;
        cmp_vec  = {bus.cmp_g, bus.cmp_e, bus.cmp_l};

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    lo_d     = '0;
                    hi_d     = HI_INIT;
                    guess_d  = GUESS_INIT;
                    probes_d = '0;
                    found_d  = 1'b0;
                    error_d  = 1'b0;
                    result_d = '0;
                    state_d  = PROBE_STATE;
                end
            end
            ST_SETTLE: begin
                if (settle_expire) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                probes_d = probes_q + PCW'(1);
                if (!(cmp_vec inside {3'b100, 3'b010, 3'b001})) begin
                    error_d = 1'b1;
                    state_d = ST_DONE;
                end else if (bus.cmp_e) begin
                    result_d = guess_q;
                    found_d  = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    // Bounds carry one extra bit so lo=2^WIDTH and hi=-1 stay distinguishable.
                    if (bus.cmp_g) lo_n = {1'b0, guess_q} + ONE_EXT;
                    else           hi_n = {1'b0, guess_q} - ONE_EXT;
                    lo_d = lo_n;
                    hi_d = hi_n;
                    if (hi_n[WIDTH] || lo_n > hi_n || probes_d == PROBE_MAX) begin
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        guess_d = WIDTH'(sar_mid(32'(lo_n), 32'(hi_n)));
                        state_d = PROBE_STATE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        // NOTE: every flop, including the search bounds, is reset so a mid-search reset leaves no stale range.
        if (rst) begin
            state_q  <= ST_IDLE;
            guess_q  <= '0;
            result_q <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            probes_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            probes_q <= probes_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            error_q  <= error_d;
        end
    end

    assign bus.guess  = guess_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.found  = found_q;
    assign bus.error  = error_q;
    assign bus.result = result_q;
    assign bus.probes = probes_q;

endmodule

// File: tb/tb_sar_search_controller.sv
// Directed bench: two controllers (SETTLE=0 and SETTLE=2) against a behavioural comparator.
module tb_sar_search_controller;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_pass   = 0;

    int target0 = 0, mode0 = 0;
    int target2 = 0, mode2 = 0;

    typedef struct {
        int guess;
        int busy;
        int done;
        int found;
        int error;
        int result;
        int probes;
    } obs_t;

    sar_search_controller_if #(.WIDTH(4), .PCW(3)) bus0 ();
    sar_search_controller_if #(.WIDTH(4), .PCW(3)) bus2 ();

    sar_search_controller #(.WIDTH(4), .SETTLE(0), .PCW(3)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    sar_search_controller #(.WIDTH(4), .SETTLE(2), .PCW(3)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    // Comparator: mode 0 honest, mode 1 always "greater", mode 2 g and e together.
    function automatic logic [2:0] cmp_fn(input int t, input logic [3:0] g, input int m);
        if (m == 1) return 3'b100;
        if (m == 2) return 3'b110;
        if (t > int'(g)) return 3'b100;
        if (t == int'(g)) return 3'b010;
        return 3'b001;
    endfunction

    assign {bus0.cmp_g, bus0.cmp_e, bus0.cmp_l} = cmp_fn(target0, bus0.guess, mode0);
    assign {bus2.cmp_g, bus2.cmp_e, bus2.cmp_l} = cmp_fn(target2, bus2.guess, mode2);

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic observe(input int sel, output obs_t o);
        if (sel == 0) begin
            o.guess  = int'(bus0.guess);
            o.busy   = int'(bus0.busy);
            o.done   = int'(bus0.done);
            o.found  = int'(bus0.found);
            o.error  = int'(bus0.error);
            o.result = int'(bus0.result);
            o.probes = int'(bus0.probes);
        end else begin
            o.guess  = int'(bus2.guess);
            o.busy   = int'(bus2.busy);
            o.done   = int'(bus2.done);
            o.found  = int'(bus2.found);
            o.error  = int'(bus2.error);
            o.result = int'(bus2.result);
            o.probes = int'(bus2.probes);
        end
    endtask

    task automatic drive_start(input int sel, input logic v);
        if (sel == 0) bus0.start = v;
        else          bus2.start = v;
    endtask

    task automatic check_all(input string tag, input int sel, input obs_t e);
        obs_t o;
        observe(sel, o);
        check($sformatf("%s_guess", tag),  o.guess,  e.guess);
        check($sformatf("%s_busy", tag),   o.busy,   e.busy);
        check($sformatf("%s_done", tag),   o.done,   e.done);
        check($sformatf("%s_found", tag),  o.found,  e.found);
        check($sformatf("%s_error", tag),  o.error,  e.error);
        check($sformatf("%s_result", tag), o.result, e.result);
        check($sformatf("%s_probes", tag), o.probes, e.probes);
    endtask

    // Integer binary search over 0..15 following the search rules directly.
    task automatic model_search(input int target, input int mode, output int gs[8],
                                output int k, output int found, output int err, output int result);
        int lo;
        int hi;
        int g;
        lo = 0; hi = 15; k = 0; found = 0; err = 0; result = 0;
        for (int i = 0; i < 8; i++) gs[i] = 0;
        for (int step = 0; step < 8; step++) begin
            g = (lo + hi + 1) / 2;
            gs[k] = g;
            k++;
            if (mode == 2) begin err = 1; break; end
            if (mode == 0 && target == g) begin found = 1; result = g; break; end
            if (mode == 1 || target > g) lo = g + 1;
            else                         hi = g - 1;
            if (lo > hi || k == 5) begin err = 1; break; end
        end
    endtask

    // One full search, compared every cycle from start acceptance to one cycle past done.
    task automatic run(input int sel, input int target, input int mode, input bit poke);
        int   gs[8];
        int   k, ef, ee, er, per;
        string tag;
        obs_t e;
        per = (sel == 0) ? 1 : 3;
        model_search(target, mode, gs, k, ef, ee, er);
        if (sel == 0) begin target0 = target; mode0 = mode; end
        else          begin target2 = target; mode2 = mode; end
        @(negedge clk);
        drive_start(sel, 1'b1);
        @(negedge clk);
        drive_start(sel, 1'b0);
        for (int c = 1; c <= k * per; c++) begin
            obs_t o;
            observe(sel, o);
            tag = $sformatf("t%0d_m%0d_d%0d_c%0d", target, mode, sel, c);
            check($sformatf("%s_guess", tag), o.guess, gs[(c - 1) / per]);
            check($sformatf("%s_busy", tag),  o.busy,  1);
            check($sformatf("%s_done", tag),  o.done,  0);
            check($sformatf("%s_found", tag), o.found, 0);
            check($sformatf("%s_error", tag), o.error, 0);
            if (poke && c == 2) drive_start(sel, 1'b1);
            if (poke && c == 3) drive_start(sel, 1'b0);
            @(negedge clk);
        end
        drive_start(sel, 1'b0);
        e = '{guess: gs[k - 1], busy: 0, done: 1, found: ef, error: ee, result: er, probes: k};
        check_all($sformatf("t%0d_m%0d_d%0d_donecyc", target, mode, sel), sel, e);
        @(negedge clk);
        e.done = 0;
        check_all($sformatf("t%0d_m%0d_d%0d_held", target, mode, sel), sel, e);
    endtask

    initial begin
        obs_t o;
        obs_t zero;
        zero = '{guess: 0, busy: 0, done: 0, found: 0, error: 0, result: 0, probes: 0};
        rst = 1'b1;
        bus0.start = 1'b0;
        bus2.start = 1'b0;
        repeat (3) @(negedge clk);
        check_all("reset_d0", 0, zero);
        check_all("reset_d2", 1, zero);
        rst = 1'b0;

        // Target at the first guess: one probe.
        run(0, 8, 0, 0);
        observe(0, o);
        check("pin_t8_result", o.result, 8);
        check("pin_t8_probes", o.probes, 1);
        check("pin_t8_found",  o.found,  1);

        // Lowest value, with a start pulse injected mid-search.
        run(0, 0, 0, 1);
        observe(0, o);
        check("pin_t0_result", o.result, 0);
        check("pin_t0_probes", o.probes, 5);

        // Highest value on the SETTLE=2 instance.
        run(1, 15, 0, 0);
        observe(1, o);
        check("pin_t15_result", o.result, 15);
        check("pin_t15_probes", o.probes, 4);
        check("pin_t15_guess",  o.guess,  15);

        // Settled instance, mid value, with a start pulse while busy.
        run(1, 6, 0, 1);
        observe(1, o);
        check("pin_t6_result", o.result, 6);

        // Comparator stuck at "greater": range exhausts.
        run(0, 0, 1, 0);
        observe(0, o);
        check("pin_stuckg_error",  o.error,  1);
        check("pin_stuckg_found",  o.found,  0);
        check("pin_stuckg_probes", o.probes, 4);
        check("pin_stuckg_guess",  o.guess,  15);

        // Non-one-hot comparator output on the first sample.
        run(0, 3, 2, 0);
        observe(0, o);
        check("pin_badhot_error",  o.error,  1);
        check("pin_badhot_probes", o.probes, 1);

        // Reset during the third probe of target 5.
        target0 = 5;
        mode0 = 0;
        @(negedge clk);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        observe(0, o);
        check("midrst_third_guess", o.guess, 6);
        rst = 1'b1;
        @(negedge clk);
        check_all("midrst_after", 0, zero);
        rst = 1'b0;
        run(0, 5, 0, 0);
        observe(0, o);
        check("pin_t5_result", o.result, 5);
        check("pin_t5_found",  o.found,  1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sar_search_controller.md
Name: sar_search_controller

Overview:
- Sequential initiator that drives the B operand of the team's combinational magnitude comparator and consumes its g/e/l outputs.
- Binary-searches (successive approximation) for the unknown value on the comparator's A operand, which is the target.
- Used wherever a hidden register or input must be recovered through compare-only access.
- Early termination on equality; flags comparator misbehaviour as an error.

Parameters:
- WIDTH, 4, operand width in bits; the search range is 0 .. 2^WIDTH-1.
- SETTLE, 0, idle cycles after each new guess before cmp_* are sampled (covers comparator/path delay).
- PCW, 3, probe-counter width; must hold WIDTH+1 (3 for WIDTH=4).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  begin a search; accepted only in IDLE
- cmp_g  input  1  comparator: target > guess
- cmp_e  input  1  comparator: target == guess
- cmp_l  input  1  comparator: target < guess
- guess  output  WIDTH  registered operand driven to the comparator B input
- busy  output  1  high in SETTLE and SAMPLE
- done  output  1  one-cycle pulse when a search ends
- found  output  1  result valid; held until next accepted start
- error  output  1  search failed; held until next accepted start
- result  output  WIDTH  located value; held until next accepted start
- probes  output  PCW  number of samples taken in the last search; held

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-search): state=IDLE; guess=0, busy=0, done=0, found=0, error=0, result=0, probes=0; lo/hi/settle counter cleared.
- Internal bounds lo and hi are WIDTH+1 bits wide, so lo=2^WIDTH and hi=-1 do not wrap; they are compared unsigned-extended, with hi underflow detected via its sign/borrow.
- Midpoint: mid = (lo + hi + 1) >> 1 (upper middle); the first guess is 2^(WIDTH-1).
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - On start: lo=0, hi=2^WIDTH-1, guess=2^(WIDTH-1), probes=0; clear found/error/result.
  - Next state is SETTLE if SETTLE>0, else SAMPLE.
- SETTLE: count SETTLE cycles, then go to SAMPLE; cmp_* are ignored.
- SAMPLE (one cycle), always increments probes. Then, in priority order:
  - cmp_* not exactly one-hot: error=1 -> DONE.
  - cmp_e: result=guess, found=1 -> DONE.
  - cmp_g: lo=guess+1.
  - cmp_l: hi=guess-1.
- After a g/l update in SAMPLE:
  - If lo>hi, or probes reaches WIDTH+1: error=1 -> DONE.
  - Otherwise guess = new mid, go to SETTLE/SAMPLE.
- DONE (one cycle): done=1, busy=0 -> IDLE. start is ignored in DONE and while busy.
- guess changes only at the IDLE->search edge and the SAMPLE edge; it is stable for SETTLE+1 cycles per probe and holds its last value in IDLE.
- Latency: start sampled at edge t, k probes taken => done is high in cycle t + k*(SETTLE+1) + 1.
- A correct comparator always gives found=1 with probes <= WIDTH+1.

Decomposition:
- Shared defines/package (sar_defs): state encodings (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3), the PCW derivation rule, and the midpoint macro.
- One natural sub-module: sar_settle_timer (load/count-down/expire). Used only when SETTLE>0; otherwise tie expire=1.
- The comparator itself stays external. The bench instantiates the existing 4-bit comparator with A=target and B=guess.

Test Plan:
- WIDTH=4, SETTLE=0, target=8, pulse start -> guess=8, one probe; done one cycle after the sample; found=1, result=8, probes=1, error=0.
- target=0 -> guess sequence 8,4,2,1,0; found=1, result=0, probes=5; done at t+6.
- target=15, SETTLE=2 -> guess sequence 8,12,14,15, each guess held 3 cycles; result=15, probes=4; done at t+13.
- Bench forces cmp_g=1 always -> guesses 8,12,14,15, then lo=16>hi; error=1, found=0, probes=4; guess never exceeds 15.
- Bench forces cmp_g=cmp_e=1 on the first sample -> error=1, probes=1, done pulse. A start pulse while busy on a normal run is ignored (the search is unaffected).
- rst asserted during the third probe of target=5 -> next cycle all outputs are 0 and state is IDLE. A fresh start then yields result=5, found=1.
